// File: rtl/mips_cpu_pkg.sv
// Shared types and default constants for the multicycle MIPS core.
// Holds the PC sequencer state encoding and default reset/halt addresses.
package mips_cpu_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        SLOT = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] DEFAULT_HALT_ADDR    = 32'h0000_0000;

endpackage

// File: rtl/pc_target_mux.sv
// Combinational priority select of the redirect target (jumpreg > jump > branch),
// plus the redirect request flag and a multi-select error flag.
module pc_target_mux #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              condition_met,
    input  logic [ADDR_W-1:0] branch_addr,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              jumpreg,
    input  logic [ADDR_W-1:0] read_data_a,
    output logic [ADDR_W-1:0] target,
    output logic              request,
    output logic              multi_sel
);

    always_comb begin
        target = '0;
        if (jumpreg) begin
            target = read_data_a;
        end else if (jump) begin
            target = jump_addr;
        end else if (condition_met) begin
            target = branch_addr;
        end
    end

    assign request   = condition_met | jump | jumpreg;
    assign multi_sel = (condition_met & jump) | (condition_met & jumpreg) | (jump & jumpreg);

endmodule

// File: rtl/pc_sequencer.sv
// Registered PC sequencer: PC register, redirect target hold, branch delay slot
// and halt-on-jump-to-HALT_ADDR. Optional misaligned-target fault: PC_ALIGN_CHECK_EN.
module pc_sequencer
    import mips_cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR),
    parameter logic [ADDR_W-1:0] HALT_ADDR    = ADDR_W'(DEFAULT_HALT_ADDR)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              advance,
    input  logic              condition_met,
    input  logic [ADDR_W-1:0] branch_addr,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              jumpreg,
    input  logic [ADDR_W-1:0] read_data_a,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] link_addr,
    output logic              delay_slot,
    output logic              halted,
    output logic              ctrl_err,
    output logic              align_fault
);

    pc_state_t         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic              delay_slot_q, delay_slot_d;
    logic              halted_q, halted_d;
    logic              ctrl_err_q, ctrl_err_d;
    logic              align_fault_q, align_fault_d;

    logic [ADDR_W-1:0] sel_target;
    logic              request;
    logic              multi_sel;

    pc_target_mux #(
        .ADDR_W (ADDR_W)
    ) u_target_mux (
        .condition_met (condition_met),
        .branch_addr   (branch_addr),
        .jump          (jump),
        .jump_addr     (jump_addr),
        .jumpreg       (jumpreg),
        .read_data_a   (read_data_a),
        .target        (sel_target),
        .request       (request),
        .multi_sel     (multi_sel)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        target_d      = target_q;
        delay_slot_d  = delay_slot_q;
        halted_d      = halted_q;
        ctrl_err_d    = ctrl_err_q;
        align_fault_d = align_fault_q;

        if (advance) begin
            case (state_q)
                RUN: begin
                    pc_d = pc_q + ADDR_W'(4);
                    if (request) begin
                        target_d     = sel_target;
                        state_d      = SLOT;
                        delay_slot_d = 1'b1;
                        if (multi_sel) begin
                            ctrl_err_d = 1'b1;
                        end
                    end
                end
                SLOT: begin
                    // A redirect issued from the delay slot itself is dropped.
                    if (request) begin
                        ctrl_err_d = 1'b1;
                    end
                    delay_slot_d = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
                    if (target_q[1:0] != 2'b00) begin
                        state_d       = HALT;
                        halted_d      = 1'b1;
                        align_fault_d = 1'b1;
                    end else
`endif
                    begin
                        pc_d = target_q;
                        if (target_q == HALT_ADDR) begin
                            state_d  = HALT;
                            halted_d = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= RUN;
            pc_q          <= RESET_VECTOR;
            target_q      <= '0;
            delay_slot_q  <= 1'b0;
            halted_q      <= 1'b0;
            ctrl_err_q    <= 1'b0;
            align_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            target_q      <= target_d;
            delay_slot_q  <= delay_slot_d;
            halted_q      <= halted_d;
            ctrl_err_q    <= ctrl_err_d;
            align_fault_q <= align_fault_d;
        end
    end

    assign pc         = pc_q;
    assign link_addr  = pc_q + ADDR_W'(8);
    assign delay_slot = delay_slot_q;
    assign halted     = halted_q;
    assign ctrl_err   = ctrl_err_q;
`ifdef PC_ALIGN_CHECK_EN
    assign align_fault = align_fault_q;
`else
    assign align_fault = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: expected PC/flag snapshots are queued
// with each stimulus cycle and compared after the clock edge.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        advance;
    logic        condition_met;
    logic [31:0] branch_addr;
    logic        jump;
    logic [31:0] jump_addr;
    logic        jumpreg;
    logic [31:0] read_data_a;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        delay_slot;
    logic        halted;
    logic        ctrl_err;
    logic        align_fault;

    typedef struct {
        logic [31:0] pc;
        logic        ds;
        logic        halted;
        logic        err;
        logic        align;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    pc_sequencer #(
        .ADDR_W       (32),
        .RESET_VECTOR (32'hBFC0_0000),
        .HALT_ADDR    (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .advance       (advance),
        .condition_met (condition_met),
        .branch_addr   (branch_addr),
        .jump          (jump),
        .jump_addr     (jump_addr),
        .jumpreg       (jumpreg),
        .read_data_a   (read_data_a),
        .pc            (pc),
        .link_addr     (link_addr),
        .delay_slot    (delay_slot),
        .halted        (halted),
        .ctrl_err      (ctrl_err),
        .align_fault   (align_fault)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic set_in(input logic adv, input logic cm, input logic [31:0] ba,
                          input logic j, input logic [31:0] ja,
                          input logic jr, input logic [31:0] rd);
        advance       = adv;
        condition_met = cm;
        branch_addr   = ba;
        jump          = j;
        jump_addr     = ja;
        jumpreg       = jr;
        read_data_a   = rd;
    endtask

    // Queue expectation for the current stimulus, clock once, then pop and compare.
    task automatic step(input string name, input logic [31:0] epc, input logic eds,
                        input logic eh, input logic ee, input logic ea);
        exp_t e;
        exp_q.push_back('{pc: epc, ds: eds, halted: eh, err: ee, align: ea});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (pc !== e.pc) $display("FAIL %s pc: got %h expected %h", name, pc, e.pc);
        else passes++;
        checks++;
        if (link_addr !== e.pc + 32'd8) $display("FAIL %s link_addr: got %h expected %h", name, link_addr, e.pc + 32'd8);
        else passes++;
        checks++;
        if (delay_slot !== e.ds) $display("FAIL %s delay_slot: got %b expected %b", name, delay_slot, e.ds);
        else passes++;
        checks++;
        if (halted !== e.halted) $display("FAIL %s halted: got %b expected %b", name, halted, e.halted);
        else passes++;
        checks++;
        if (ctrl_err !== e.err) $display("FAIL %s ctrl_err: got %b expected %b", name, ctrl_err, e.err);
        else passes++;
        checks++;
        if (align_fault !== e.align) $display("FAIL %s align_fault: got %b expected %b", name, align_fault, e.align);
        else passes++;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        set_in(1'b1, 1'b1, 32'h1234_5678, 1'b1, 32'h8765_4320, 1'b0, '0);
        step("reset", 32'hBFC0_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        set_in(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic test_reset();
        do_reset();
        step("reset_idle", 32'hBFC0_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_sequential();
        set_in(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        step("seq1", 32'hBFC0_0004, 1'b0, 1'b0, 1'b0, 1'b0);
        step("seq2", 32'hBFC0_0008, 1'b0, 1'b0, 1'b0, 1'b0);
        step("seq3", 32'hBFC0_000C, 1'b0, 1'b0, 1'b0, 1'b0);
        step("seq4", 32'hBFC0_0010, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_branch();
        set_in(1'b1, 1'b1, 32'hBFC0_0100, 1'b0, '0, 1'b0, '0);
        step("branch_slot", 32'hBFC0_0014, 1'b1, 1'b0, 1'b0, 1'b0);
        set_in(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        step("branch_target", 32'hBFC0_0100, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_hold();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b1, 32'hDEAD_0000, 1'b1, 32'hBEEF_0000, 1'b1, 32'hCAFE_0000);
            step("hold_run", 32'hBFC0_0100, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_multi_select();
        set_in(1'b1, 1'b0, '0, 1'b1, 32'hBFC0_0200, 1'b1, 32'hBFC0_0300);
        step("multi_slot", 32'hBFC0_0104, 1'b1, 1'b0, 1'b1, 1'b0);
        set_in(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        step("multi_target", 32'hBFC0_0300, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_branch_in_slot();
        do_reset();
        set_in(1'b1, 1'b1, 32'hBFC0_0400, 1'b0, '0, 1'b0, '0);
        step("bis_slot", 32'hBFC0_0004, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, i[0], 32'hBFC0_0600, 1'b0, '0, 1'b0, '0);
            step("bis_hold", 32'hBFC0_0004, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        set_in(1'b1, 1'b1, 32'hBFC0_0500, 1'b0, '0, 1'b0, '0);
        step("bis_target", 32'hBFC0_0400, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_slot();
        set_in(1'b1, 1'b0, '0, 1'b1, 32'hBFC0_0800, 1'b0, '0);
        step("rms_slot", 32'hBFC0_0404, 1'b1, 1'b0, 1'b1, 1'b0);
        do_reset();
        set_in(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        step("rms_discard1", 32'hBFC0_0004, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rms_discard2", 32'hBFC0_0008, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        set_in(1'b1, 1'b0, '0, 1'b1, 32'hFFFF_FFF8, 1'b0, '0);
        step("wrap_slot", 32'hBFC0_000C, 1'b1, 1'b0, 1'b0, 1'b0);
        set_in(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        step("wrap_target", 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b0, 1'b0);
        step("wrap_top", 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 1'b0);
        step("wrap_zero", 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        step("wrap_four", 32'h0000_0004, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_halt();
        do_reset();
        set_in(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 32'h0000_0000);
        step("halt_slot", 32'hBFC0_0004, 1'b1, 1'b0, 1'b0, 1'b0);
        set_in(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        step("halt_enter", 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b1, 32'hBFC0_0100, 1'b1, 32'hBFC0_0200, 1'b0, '0);
            step("halt_frozen", 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        set_in(1'b1, 1'b0, '0, 1'b1, 32'hBFC0_0202, 1'b0, '0);
        step("mis_slot", 32'hBFC0_0004, 1'b1, 1'b0, 1'b0, 1'b0);
        set_in(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
`ifdef PC_ALIGN_CHECK_EN
        step("mis_fault", 32'hBFC0_0004, 1'b0, 1'b1, 1'b0, 1'b1);
        step("mis_frozen", 32'hBFC0_0004, 1'b0, 1'b1, 1'b0, 1'b1);
`else
        step("mis_verbatim", 32'hBFC0_0202, 1'b0, 1'b0, 1'b0, 1'b0);
        step("mis_next", 32'hBFC0_0206, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
    endtask

    initial begin
        reset_n = 1'b0;
        set_in(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        #1;
        test_reset();
        test_sequential();
        test_branch();
        test_hold();
        test_multi_select();
        test_branch_in_slot();
        test_reset_mid_slot();
        test_wrap();
        test_halt();
        test_misaligned();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
